// File: rtl/cpu_rf_pkg.sv
// cpu_rf_pkg: shared sizing and types for the CPU register file.
package cpu_rf_pkg;
    localparam int RF_ENTRIES = 16;
    localparam int RF_AW = 4;
    localparam int DEF_DATA_W = 32;
    typedef logic [RF_ENTRIES-1:0] rf_sel_t;
    typedef logic [RF_AW-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_onehot16_check.sv
// onehot16_check: validates a one-hot write select and encodes its index.
module onehot16_check
    import cpu_rf_pkg::*;
(
    input  rf_sel_t  wsel,
    output logic     is_onehot,
    output rf_addr_t index
);
    // A power of two is the only nonzero value with no bits left after clearing its lowest set bit.
    assign is_onehot = (wsel != '0) && ((wsel & (wsel - rf_sel_t'(1))) == '0);
    always_comb begin
        index = '0;
        for (int i = 0; i < RF_ENTRIES; i++)
            index = index | (wsel[i] ? rf_addr_t'(i) : rf_addr_t'(0));
    end
endmodule

// File: rtl/regfile_onehot16.sv
// regfile_onehot16: 16-entry register file with one-hot write select, write-through bypass
// and malformed-select reporting.
module regfile_onehot16
    import cpu_rf_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter bit ZERO_REG  = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  rf_sel_t              wsel,
    input  logic [DATA_W-1:0]    wdata,
    input  rf_addr_t             raddr_a,
    input  rf_addr_t             raddr_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic                 wsel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [DATA_W-1:0]    mem_q [RF_ENTRIES];
    logic [DATA_W-1:0]    mem_d [RF_ENTRIES];
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 is_onehot;
    rf_addr_t             widx;
    logic                 wr_en;

    onehot16_check u_check (
        .wsel      (wsel),
        .is_onehot (is_onehot),
        .index     (widx)
    );

    // Writes to the hardwired zero entry are dropped here so they also never bypass.
    assign wr_en = we && is_onehot && !(ZERO_REG && widx == '0);
    assign err_d = we && !is_onehot;
    assign cnt_d = (err_d && !(&cnt_q)) ? cnt_q + ERR_CNT_W'(1) : cnt_q;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[widx] = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_a  = (ZERO_REG && raddr_a == '0) ? '0 :
                      (wr_en && widx == raddr_a) ? wdata : mem_q[raddr_a];
    assign rdata_b  = (ZERO_REG && raddr_b == '0) ? '0 :
                      (wr_en && widx == raddr_b) ? wdata : mem_q[raddr_b];
    assign wsel_err = err_q;
    assign err_cnt  = cnt_q;
endmodule

// File: tb/tb_regfile_onehot16.sv
// tb_regfile_onehot16: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_regfile_onehot16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [15:0] wsel = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  raddr_a = '0, raddr_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        wsel_err;
  logic [7:0]  err_cnt;
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  int   req = 0, ack = 0;
  int   checks = 0, errors = 0;
  regfile_onehot16 #(.DATA_W(32), .ZERO_REG(1'b1), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .wsel_err(wsel_err), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    forever begin
      wait (req != ack);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        act = (e.kind == 0) ? rdata_a : (e.kind == 1) ? rdata_b :
              (e.kind == 2) ? {31'd0, wsel_err} : {24'd0, err_cnt};
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
        end
      end
      ack = req;
    end
  end
  task automatic expect_v(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask
  task automatic sample();
    #1;
    req++;
    wait (ack == req);
  endtask
  task automatic drive(input logic w, input logic [15:0] s, input logic [31:0] d,
                       input logic [3:0] ra, input logic [3:0] rb);
    we = w; wsel = s; wdata = d; raddr_a = ra; raddr_b = rb;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  int exp_cnt;
  initial begin
    #12 rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0, 32'h0, 4'(i), 4'(15 - i));
      expect_v($sformatf("reset_rd_a%0d", i), 0, 32'h0);
      expect_v($sformatf("reset_rd_b%0d", 15 - i), 1, 32'h0);
      sample();
    end
    expect_v("reset_err", 2, 32'h0);
    expect_v("reset_cnt", 3, 32'h0);
    sample();
    drive(1'b1, 16'h0020, 32'hDEADBEEF, 4'd1, 4'd2);
    tick();
    drive(1'b0, 16'h0, 32'h0, 4'd5, 4'd5);
    expect_v("wr5_rd_a", 0, 32'hDEADBEEF);
    expect_v("wr5_rd_b", 1, 32'hDEADBEEF);
    expect_v("wr5_err", 2, 32'h0);
    sample();
    checks++;
    if (rdata_a !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL direct_wr5: got %h", rdata_a);
    end
    drive(1'b1, 16'h0200, 32'h12345678, 4'd9, 4'd9);
    expect_v("byp9_a", 0, 32'h12345678);
    expect_v("byp9_b", 1, 32'h12345678);
    sample();
    tick();
    drive(1'b0, 16'h0, 32'h0, 4'd9, 4'd5);
    expect_v("st9_a", 0, 32'h12345678);
    expect_v("st5_b", 1, 32'hDEADBEEF);
    sample();
    drive(1'b1, 16'h0080, 32'h0BADF00D, 4'd7, 4'd5);
    expect_v("byp7_a", 0, 32'h0BADF00D);
    expect_v("nobyp5_b", 1, 32'hDEADBEEF);
    sample();
    tick();
    drive(1'b1, 16'h0001, 32'hCAFEF00D, 4'd0, 4'd0);
    expect_v("zero_byp_a", 0, 32'h0);
    expect_v("zero_byp_b", 1, 32'h0);
    expect_v("zero_wr_noerr", 2, 32'h0);
    sample();
    tick();
    drive(1'b0, 16'h0, 32'h0, 4'd0, 4'd7);
    expect_v("zero_after_a", 0, 32'h0);
    expect_v("st7_b", 1, 32'h0BADF00D);
    expect_v("zero_wr_noerr2", 2, 32'h0);
    sample();
    drive(1'b1, 16'h0011, 32'hFFFFFFFF, 4'd4, 4'd5);
    expect_v("rej_nobyp_a", 0, 32'h0);
    expect_v("rej_nobyp_b", 1, 32'hDEADBEEF);
    sample();
    tick();
    drive(1'b0, 16'h0, 32'h0, 4'd4, 4'd0);
    expect_v("rej_e4", 0, 32'h0);
    expect_v("rej_err1", 2, 32'h1);
    expect_v("rej_cnt1", 3, 32'h1);
    sample();
    tick();
    expect_v("rej_err_pulse_end", 2, 32'h0);
    expect_v("rej_cnt1_hold", 3, 32'h1);
    sample();
    drive(1'b1, 16'h0000, 32'h55555555, 4'd4, 4'd5);
    tick();
    expect_v("rej0_err", 2, 32'h1);
    expect_v("rej0_cnt2", 3, 32'h2);
    sample();
    drive(1'b0, 16'h0011, 32'hFFFFFFFF, 4'd4, 4'd5);
    tick();
    expect_v("we0_err", 2, 32'h0);
    expect_v("we0_cnt2", 3, 32'h2);
    expect_v("we0_e4", 0, 32'h0);
    expect_v("we0_e5", 1, 32'hDEADBEEF);
    sample();
    exp_cnt = 2;
    drive(1'b1, 16'hFFFF, 32'h77777777, 4'd5, 4'd9);
    for (int k = 0; k < 260; k++) begin
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      expect_v($sformatf("sat_err_%0d", k), 2, 32'h1);
      expect_v($sformatf("sat_cnt_%0d", k), 3, 32'(exp_cnt));
      sample();
    end
    drive(1'b0, 16'h0, 32'h0, 4'd5, 4'd9);
    tick();
    expect_v("sat_hold_err", 2, 32'h0);
    expect_v("sat_hold_cnt", 3, 32'hFF);
    expect_v("sat_e5", 0, 32'hDEADBEEF);
    expect_v("sat_e9", 1, 32'h12345678);
    sample();
    drive(1'b1, 16'h0008, 32'hA5A5A5A5, 4'd3, 4'd3);
    tick();
    drive(1'b0, 16'h0, 32'h0, 4'd3, 4'd5);
    expect_v("wr3_a", 0, 32'hA5A5A5A5);
    sample();
    #1 rst = 1'b1;
    expect_v("arst_e3", 0, 32'h0);
    expect_v("arst_e5", 1, 32'h0);
    expect_v("arst_err", 2, 32'h0);
    expect_v("arst_cnt", 3, 32'h0);
    sample();
    checks++;
    if (rdata_a !== 32'h0) begin
      errors++;
      $display("FAIL direct_arst_e3: got %h", rdata_a);
    end
    #1 rst = 1'b0;
    tick();
    expect_v("post_rst_e3", 0, 32'h0);
    expect_v("post_rst_cnt", 3, 32'h0);
    sample();
    checks++;
    if (err_cnt !== 8'h0) begin
      errors++;
      $display("FAIL direct_post_rst_cnt: got %h", err_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule

// File: doc/regfile_onehot16.md
Name: regfile_onehot16

Overview:
- 16-entry general-purpose register file for the CPU datapath, directly downstream of the 4-to-16 write-address decoder.
- Consumes the decoder's one-hot 16-bit write select. Provides two combinational read ports with write-through bypass.
- Validates the one-hot select and reports malformed selects to debug logic via a pulse and a saturating counter.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ZERO_REG, 1, when 1 entry 0 always reads as zero and writes to it are discarded; when 0 entry 0 is an ordinary register.
- ERR_CNT_W, 8, width of the saturating malformed-select counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- we  input  1  write enable from the write-back stage.
- wsel  input  16  one-hot write select from the 4-to-16 decoder; bit i selects entry i.
- wdata  input  DATA_W  write data.
- raddr_a  input  4  read address, port A.
- raddr_b  input  4  read address, port B.
- rdata_a  output  DATA_W  read data, port A; combinational.
- rdata_b  output  DATA_W  read data, port B; combinational.
- wsel_err  output  1  registered one-cycle pulse flagging a rejected write.
- err_cnt  output  ERR_CNT_W  count of rejected writes; saturates at all-ones.

Behaviour:
- Reset (rst=1, asynchronous):
  - All 16 entries clear to 0.
  - wsel_err clears to 0 and err_cnt clears to 0.
  - The clear takes effect immediately, independent of clk. A write in flight in the same cycle is lost.
- Write valid condition: we=1 and wsel has exactly one bit set (popcount==1).
- Valid write: entry i (wsel[i]=1) takes wdata at the next rising edge.
  - Exception: if ZERO_REG=1 and i=0, the write is silently dropped. This is not an error.
- Rejected write: we=1 and popcount(wsel) is 0 or 2 or more.
  - No entry changes.
  - wsel_err=1 for exactly the following cycle.
  - err_cnt increments by 1, holding at 2^ERR_CNT_W-1.
- we=0: wsel is ignored entirely; no write and no error, even if wsel is malformed.
- Back-to-back rejected writes: wsel_err stays high on each following cycle and err_cnt increments on every cycle.
- Reads: rdata_x = entry[raddr_x], with zero latency (combinational).
- Zero register: if ZERO_REG=1 and raddr_x=0, rdata_x=0 unconditionally, including under bypass.
- Bypass: if a valid write targets raddr_x in the same cycle, rdata_x = wdata, not the stored value.
  - Bypass never applies to a rejected write.
  - Both ports may bypass simultaneously, including when both read the same address.
- Read-during-reset: rdata reflects the cleared (zero) array.
- No X propagation: an out-of-range condition is impossible with 4-bit addresses, and every output is defined for all inputs.

Decomposition:
- Shared package `cpu_rf_pkg`:
  - RF_ENTRIES=16
  - RF_AW=4
  - default DATA_W=32
  - typedef for the one-hot select vector
- Sub-module `onehot16_check`: combinational; input wsel[15:0]; outputs is_onehot and index[3:0], the encoded write index used by the bypass compare.
- The register array, error logic and read muxes remain in regfile_onehot16.

Test Plan:
1. Reset then read: assert rst, release, read all 16 addresses on both ports -> every rdata=0, wsel_err=0, err_cnt=0.
2. Basic write/read: we=1, wsel=16'h0020, wdata=32'hDEADBEEF for one cycle; next cycle raddr_a=5 -> rdata_a=32'hDEADBEEF.
3. Same-cycle bypass:
   - we=1, wsel=16'h0200, wdata=32'h12345678, raddr_a=9, raddr_b=9 -> both rdata=32'h12345678 in that cycle, before the edge.
   - Repeat with wsel=16'h0001, ZERO_REG=1 -> rdata=0 and entry 0 is still 0 afterwards.
4. Malformed select:
   - we=1, wsel=16'h0011, wdata=32'hFFFFFFFF -> entries 0 and 4 unchanged; wsel_err=1 for the next cycle only; err_cnt=1.
   - Then wsel=16'h0000 with we=1 -> err_cnt=2.
   - Then wsel=16'h0011 with we=0 -> no error; err_cnt stays 2.
5. Counter saturation: 260 consecutive rejected writes -> err_cnt reaches 8'hFF and holds; wsel_err stays high throughout.
6. Asynchronous reset mid-operation: write 32'hA5A5A5A5 to entry 3, then pulse rst between clock edges -> rdata for address 3 reads 0 immediately, and err_cnt=0.
